// File: rtl/jk_excite_driver.sv
// JK flop initiator: buffers target q bits, drives the J/K excitation for each one,
// and checks the returned q one cycle after the flop samples it.
module jk_excite_driver #(
  parameter int DEPTH         = 8,
  parameter bit PREFER_TOGGLE = 1'b0,
  parameter int CNT_W         = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             reinit,
  input  logic             tgt_valid,
  output logic             tgt_ready,
  input  logic             tgt_bit,
  output logic             j,
  output logic             k,
  output logic             jk_rst,
  input  logic             q,
  output logic             busy,
  output logic             mismatch,
  output logic             init_fail,
  output logic [CNT_W-1:0] err_cnt,
  output logic [CNT_W-1:0] done_cnt
);
  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] PTR_ONE = (AW+1)'(1);
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  typedef enum logic [2:0] {S_RST1, S_RST2, S_RSTCHK, S_IDLE, S_WAIT, S_CHECK} state_t;
  state_t state, state_nx;

  logic [DEPTH-1:0] mem;
  logic [AW:0]      wr_ptr, rd_ptr;
  logic             full, empty, push, pop, head, q_exp;
  logic [1:0]       jk_nx;
  logic             jrst_nx;

  function automatic logic [1:0] exc(input logic cur, input logic t);
    if (cur == t) return 2'b00;
    if (PREFER_TOGGLE) return 2'b11;
    return t ? 2'b10 : 2'b01;
  endfunction

  // Extra pointer bit distinguishes full from empty when the indices match.
  assign empty     = (wr_ptr == rd_ptr);
  assign full      = ((wr_ptr ^ rd_ptr) == {1'b1, {AW{1'b0}}});
  assign head      = mem[rd_ptr[AW-1:0]];
  assign tgt_ready = !(state inside {S_RST1, S_RST2, S_RSTCHK}) && !full;
  assign push      = tgt_valid && tgt_ready;
  assign busy      = (state != S_IDLE) || !empty;

  always_ff @(posedge clk) begin
    if (!rst_n) state <= S_RST1;
    else        state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    pop      = 1'b0;
    jk_nx    = 2'b00;
    jrst_nx  = 1'b0;
    case (state)
      S_RST1:   begin state_nx = S_RST2; jrst_nx = 1'b1; end
      S_RST2:   state_nx = S_RSTCHK;
      S_RSTCHK: state_nx = S_IDLE;
      S_IDLE: begin
        if (reinit) begin
          state_nx = S_RST1;
          jrst_nx  = 1'b1;
        end else if (!empty) begin
          pop      = 1'b1;
          jk_nx    = exc(q_exp, head);
          state_nx = S_WAIT;
        end
      end
      S_WAIT:   state_nx = S_CHECK;
      S_CHECK:  state_nx = S_IDLE;
      default:  state_nx = S_RST1;
    endcase
  end

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr[AW-1:0]] <= tgt_bit;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      q_exp     <= 1'b0;
      j         <= 1'b0;
      k         <= 1'b0;
      jk_rst    <= 1'b1;
      mismatch  <= 1'b0;
      init_fail <= 1'b0;
      err_cnt   <= '0;
      done_cnt  <= '0;
    end else begin
      {j, k}   <= jk_nx;
      jk_rst   <= jrst_nx;
      mismatch <= 1'b0;
      if (push) wr_ptr <= wr_ptr + PTR_ONE;
      if (pop) begin
        rd_ptr <= rd_ptr + PTR_ONE;
        q_exp  <= head;
      end
      case (state)
        S_RSTCHK: begin
          if (q) init_fail <= 1'b1;
          q_exp <= 1'b0;
        end
        S_IDLE: if (reinit) init_fail <= 1'b0;
        S_CHECK: begin
          // Resync to the observed q so one upset does not cascade.
          if (q != q_exp) begin
            mismatch <= 1'b1;
            q_exp    <= q;
            if (err_cnt != '1) err_cnt <= err_cnt + CNT_ONE;
          end
          done_cnt <= done_cnt + CNT_ONE;
        end
        default: ;
      endcase
    end
  end
endmodule

// File: tb/tb_jk_excite_driver.sv
// Bench for jk_excite_driver: two instances (set/reset and toggle styles) each drive a
// behavioural JK flop; completions are scored against a target-level reference model.
module tb_jk_excite_driver;
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst_n = 1'b0, reinit = 1'b0, tgt_valid = 1'b0, tgt_bit = 1'b0, frc = 1'b0, fv = 1'b0;
  logic rdy0, rdy1, j0, k0, j1, k1, jr0, jr1, q0, q1, busy0, busy1, mm0, mm1, if0, if1;
  logic [7:0] err0, done0;
  logic [2:0] err1, done1;
  logic fq0, fq1;

  jk_excite_driver #(.DEPTH(8), .PREFER_TOGGLE(1'b0), .CNT_W(8)) dut0 (
    .clk(clk), .rst_n(rst_n), .reinit(reinit), .tgt_valid(tgt_valid), .tgt_ready(rdy0),
    .tgt_bit(tgt_bit), .j(j0), .k(k0), .jk_rst(jr0), .q(q0), .busy(busy0),
    .mismatch(mm0), .init_fail(if0), .err_cnt(err0), .done_cnt(done0));
  jk_excite_driver #(.DEPTH(8), .PREFER_TOGGLE(1'b1), .CNT_W(3)) dut1 (
    .clk(clk), .rst_n(rst_n), .reinit(reinit), .tgt_valid(tgt_valid), .tgt_ready(rdy1),
    .tgt_bit(tgt_bit), .j(j1), .k(k1), .jk_rst(jr1), .q(q1), .busy(busy1),
    .mismatch(mm1), .init_fail(if1), .err_cnt(err1), .done_cnt(done1));

  // Behavioural JK flops; frc overrides the q seen by the drivers.
  always @(posedge clk) begin
    if (jr0 === 1'b1) fq0 <= 1'b0;
    else if ({j0, k0} === 2'b10) fq0 <= 1'b1;
    else if ({j0, k0} === 2'b01) fq0 <= 1'b0;
    else if ({j0, k0} === 2'b11) fq0 <= ~fq0;
    if (jr1 === 1'b1) fq1 <= 1'b0;
    else if ({j1, k1} === 2'b10) fq1 <= 1'b1;
    else if ({j1, k1} === 2'b01) fq1 <= 1'b0;
    else if ({j1, k1} === 2'b11) fq1 <= ~fq1;
  end
  assign q0 = frc ? fv : fq0;
  assign q1 = frc ? fv : fq1;

  typedef struct packed {
    logic [1:0][1:0] jk;
    logic [1:0]      q;
    logic [1:0]      mm;
    logic [1:0][7:0] err;
    logic [1:0][7:0] done;
  } rec_t;

  int vecs = 0, fails = 0, spur = 0;
  rec_t recq[$];
  logic tq[$];
  logic mq[2];
  int merr[2], mdone[2];

  // One record per completion: j/k from the drive cycle, q from the check cycle.
  logic [1:0] jk0d1, jk0d2, jk1d1, jk1d2;
  logic q0d1, q1d1;
  logic [7:0] done_p;
  always @(negedge clk) begin
    if (rst_n === 1'b1 && done0 !== done_p)
      recq.push_back({jk1d2, jk0d2, q1d1, q0d1, mm1, mm0, {5'b0, err1}, err0, {5'b0, done1}, done0});
    else if (rst_n === 1'b1 && (mm0 === 1'b1 || mm1 === 1'b1))
      spur <= spur + 1;
    jk0d2 <= jk0d1; jk0d1 <= {j0, k0};
    jk1d2 <= jk1d1; jk1d1 <= {j1, k1};
    q0d1 <= q0; q1d1 <= q1;
    done_p <= done0;
  end

  function automatic logic [1:0] exc(input logic cur, input logic t, input bit pt);
    if (cur == t) return 2'b00;
    if (pt) return 2'b11;
    return t ? 2'b10 : 2'b01;
  endfunction

  task automatic model_step(input int i, input logic t, input logic qc,
                            output logic [1:0] ejk, output logic emm);
    int cmax;
    cmax = (i == 1) ? 7 : 255;
    ejk  = exc(mq[i], t, i == 1);
    emm  = (qc !== t);
    mq[i] = emm ? qc : t;
    if (emm && merr[i] < cmax) merr[i]++;
    mdone[i] = (mdone[i] + 1) & cmax;
  endtask

  task automatic model_clear();
    for (int i = 0; i < 2; i++) begin mq[i] = 1'b0; merr[i] = 0; mdone[i] = 0; end
    tq.delete();
    recq.delete();
  endtask

  task automatic do_reset();
    rst_n = 1'b0; reinit = 1'b0; tgt_valid = 1'b0; frc = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (3) @(negedge clk);
    model_clear();
  endtask

  task automatic push(input logic b);
    int n = 0;
    tgt_valid = 1'b1; tgt_bit = b;
    while (rdy0 !== 1'b1 && n < 500) begin @(negedge clk); n++; end
    if (n >= 500) begin
      vecs++; fails++;
      $display("FAIL push_timeout ready=%b want 1", rdy0);
    end else begin
      tq.push_back(b);
    end
    @(negedge clk);
    tgt_valid = 1'b0;
  endtask

  task automatic wait_idle();
    int n = 0;
    while (busy0 !== 1'b0 && n < 2000) begin @(negedge clk); n++; end
    if (n >= 2000) begin
      vecs++; fails++;
      $display("FAIL idle_timeout busy=%b want 0", busy0);
    end
    repeat (2) @(negedge clk);
  endtask

  task automatic test_reset();
    logic ejr, erdy;
    rst_n = 1'b0; tgt_valid = 1'b0; reinit = 1'b0; frc = 1'b0;
    repeat (3) @(negedge clk);
    vecs++;
    if ({jr0, j0, k0, mm0, if0, err0, done0, jr1, mm1, if1, err1, done1} !==
        {1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 8'd0, 8'd0, 1'b1, 1'b0, 1'b0, 3'd0, 3'd0}) begin
      fails++;
      $display("FAIL reset_state got jr=%b jk=%b%b mm=%b if=%b err=%0d done=%0d want jr=1 rest 0",
               jr0, j0, k0, mm0, if0, err0, done0);
    end
    rst_n = 1'b1;
    for (int c = 0; c < 4; c++) begin
      ejr = (c < 2); erdy = (c == 3);
      vecs++;
      if ({jr0, rdy0, jr1, rdy1} !== {ejr, erdy, ejr, erdy}) begin
        fails++;
        $display("FAIL init_seq cycle %0d got jk_rst=%b ready=%b want %b %b", c, jr0, rdy0, ejr, erdy);
      end
      @(negedge clk);
    end
    vecs++;
    if ({if0, if1} !== 2'b00) begin
      fails++; $display("FAIL init_fail_clean got %b%b want 00", if0, if1);
    end
    model_clear();
  endtask

  task automatic test_sequence();
    rec_t r; logic t; logic [1:0] ejk; logic emm;
    do_reset();
    push(1'b0); push(1'b1); push(1'b1); push(1'b0);
    wait_idle();
    while (recq.size() > 0) begin
      r = recq.pop_front();
      if (tq.size() == 0) begin vecs++; fails++; $display("FAIL seq_extra got done=%0d want none", r.done[0]); continue; end
      t = tq.pop_front();
      for (int i = 0; i < 2; i++) begin
        model_step(i, t, r.q[i], ejk, emm);
        vecs++;
        if ({r.jk[i], r.mm[i], r.err[i], r.done[i]} !== {ejk, emm, 8'(merr[i]), 8'(mdone[i])}) begin
          fails++;
          $display("FAIL seq inst%0d got jk=%b mm=%b err=%0d done=%0d want jk=%b mm=%b err=%0d done=%0d",
                   i, r.jk[i], r.mm[i], r.err[i], r.done[i], ejk, emm, merr[i], mdone[i]);
        end
      end
    end
    vecs++;
    if (tq.size() != 0 || done0 !== 8'd4 || err0 !== 8'd0 || q0 !== 1'b0 || q1 !== 1'b0) begin
      fails++;
      $display("FAIL seq_final got left=%0d done=%0d err=%0d q=%b%b want 0 4 0 00", tq.size(), done0, err0, q0, q1);
    end
  endtask

  task automatic test_mismatch();
    rec_t r; logic t; logic [1:0] ejk; logic emm;
    do_reset();
    push(1'b0);
    @(negedge clk);
    @(negedge clk);
    frc = 1'b1; fv = 1'b1;
    @(negedge clk);
    frc = 1'b0;
    vecs++;
    if ({mm0, err0, mm1, err1} !== {1'b1, 8'd1, 1'b1, 3'd1}) begin
      fails++; $display("FAIL mm_pulse got mm=%b err=%0d want 1 1", mm0, err0);
    end
    @(negedge clk);
    vecs++;
    if ({mm0, mm1} !== 2'b00) begin
      fails++; $display("FAIL mm_one_cycle got %b%b want 00", mm0, mm1);
    end
    push(1'b0);
    wait_idle();
    while (recq.size() > 0) begin
      r = recq.pop_front();
      if (tq.size() == 0) begin vecs++; fails++; $display("FAIL mm_extra got done=%0d want none", r.done[0]); continue; end
      t = tq.pop_front();
      for (int i = 0; i < 2; i++) begin
        model_step(i, t, r.q[i], ejk, emm);
        vecs++;
        if ({r.jk[i], r.mm[i], r.err[i], r.done[i]} !== {ejk, emm, 8'(merr[i]), 8'(mdone[i])}) begin
          fails++;
          $display("FAIL mm inst%0d got jk=%b mm=%b err=%0d done=%0d want jk=%b mm=%b err=%0d done=%0d",
                   i, r.jk[i], r.mm[i], r.err[i], r.done[i], ejk, emm, merr[i], mdone[i]);
        end
      end
    end
    vecs++;
    if (err0 !== 8'd1 || done0 !== 8'd2) begin
      fails++; $display("FAIL mm_final got err=%0d done=%0d want 1 2", err0, done0);
    end
  endtask

  task automatic test_back_to_back();
    rec_t r; logic t; logic [1:0] ejk; logic emm;
    logic vals[16];
    int idx = 0, n = 0, nfull = 0;
    do_reset();
    for (int i = 0; i < 16; i++) vals[i] = 1'($urandom);
    while (idx < 16 && n < 500) begin
      tgt_valid = 1'b1; tgt_bit = vals[idx];
      if (rdy0 === 1'b1) begin tq.push_back(vals[idx]); idx++; end
      else nfull++;
      @(negedge clk);
      n++;
    end
    tgt_valid = 1'b0;
    wait_idle();
    while (recq.size() > 0) begin
      r = recq.pop_front();
      if (tq.size() == 0) begin vecs++; fails++; $display("FAIL b2b_extra got done=%0d want none", r.done[0]); continue; end
      t = tq.pop_front();
      for (int i = 0; i < 2; i++) begin
        model_step(i, t, r.q[i], ejk, emm);
        vecs++;
        if ({r.jk[i], r.mm[i], r.err[i], r.done[i]} !== {ejk, emm, 8'(merr[i]), 8'(mdone[i])}) begin
          fails++;
          $display("FAIL b2b inst%0d got jk=%b mm=%b err=%0d done=%0d want jk=%b mm=%b err=%0d done=%0d",
                   i, r.jk[i], r.mm[i], r.err[i], r.done[i], ejk, emm, merr[i], mdone[i]);
        end
      end
    end
    vecs++;
    if (nfull == 0 || idx != 16 || tq.size() != 0 || done0 !== 8'd16) begin
      fails++;
      $display("FAIL b2b_flow got full_cycles=%0d pushed=%0d left=%0d done=%0d want >0 16 0 16",
               nfull, idx, tq.size(), done0);
    end
  endtask

  task automatic test_saturate();
    rec_t r; logic t; logic [1:0] ejk; logic emm;
    do_reset();
    frc = 1'b1; fv = 1'b1;
    for (int i = 0; i < 10; i++) push(1'b0);
    wait_idle();
    frc = 1'b0;
    while (recq.size() > 0) begin
      r = recq.pop_front();
      if (tq.size() == 0) begin vecs++; fails++; $display("FAIL sat_extra got done=%0d want none", r.done[0]); continue; end
      t = tq.pop_front();
      for (int i = 0; i < 2; i++) begin
        model_step(i, t, r.q[i], ejk, emm);
        vecs++;
        if ({r.jk[i], r.mm[i], r.err[i], r.done[i]} !== {ejk, emm, 8'(merr[i]), 8'(mdone[i])}) begin
          fails++;
          $display("FAIL sat inst%0d got jk=%b mm=%b err=%0d done=%0d want jk=%b mm=%b err=%0d done=%0d",
                   i, r.jk[i], r.mm[i], r.err[i], r.done[i], ejk, emm, merr[i], mdone[i]);
        end
      end
    end
    vecs++;
    if ({err0, done0, err1, done1} !== {8'd10, 8'd10, 3'd7, 3'd2}) begin
      fails++;
      $display("FAIL sat_counts got err0=%0d done0=%0d err1=%0d done1=%0d want 10 10 7 2", err0, done0, err1, done1);
    end
  endtask

  task automatic test_reinit();
    rst_n = 1'b0; frc = 1'b1; fv = 1'b1; tgt_valid = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (3) @(negedge clk);
    vecs++;
    if ({if0, if1} !== 2'b11) begin
      fails++; $display("FAIL init_fail_set got %b%b want 11", if0, if1);
    end
    frc = 1'b0;
    model_clear();
    push(1'b1);
    // A target is waiting, so this cycle would otherwise pop it.
    reinit = 1'b1;
    @(negedge clk);
    reinit = 1'b0;
    vecs++;
    if ({if0, jr0, j0, k0, rdy0} !== 5'b01000) begin
      fails++; $display("FAIL reinit_entry got if=%b jr=%b jk=%b%b rdy=%b want 0 1 00 0", if0, jr0, j0, k0, rdy0);
    end
    wait_idle();
    vecs++;
    if ({if0, if1, done0, err0, q0} !== {1'b0, 1'b0, 8'd1, 8'd0, 1'b1}) begin
      fails++; $display("FAIL reinit_after got if=%b%b done=%0d err=%0d q=%b want 00 1 0 1", if0, if1, done0, err0, q0);
    end
    model_clear();
  endtask

  task automatic test_midreset();
    do_reset();
    push(1'b1); push(1'b0);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    repeat (3) @(negedge clk);
    vecs++;
    if ({busy0, mm0, done0, err0, recq.size() == 0} !== {1'b0, 1'b0, 8'd0, 8'd0, 1'b1}) begin
      fails++;
      $display("FAIL midreset got busy=%b mm=%b done=%0d err=%0d recs=%0d want 0 0 0 0 0",
               busy0, mm0, done0, err0, recq.size());
    end
    model_clear();
  endtask

  task automatic test_random();
    rec_t r; logic t; logic [1:0] ejk; logic emm;
    do_reset();
    for (int i = 0; i < 40; i++) begin
      push(1'($urandom));
      repeat ($urandom_range(0, 3)) @(negedge clk);
    end
    wait_idle();
    while (recq.size() > 0) begin
      r = recq.pop_front();
      if (tq.size() == 0) begin vecs++; fails++; $display("FAIL rnd_extra got done=%0d want none", r.done[0]); continue; end
      t = tq.pop_front();
      for (int i = 0; i < 2; i++) begin
        model_step(i, t, r.q[i], ejk, emm);
        vecs++;
        if ({r.jk[i], r.mm[i], r.err[i], r.done[i]} !== {ejk, emm, 8'(merr[i]), 8'(mdone[i])}) begin
          fails++;
          $display("FAIL rnd inst%0d got jk=%b mm=%b err=%0d done=%0d want jk=%b mm=%b err=%0d done=%0d",
                   i, r.jk[i], r.mm[i], r.err[i], r.done[i], ejk, emm, merr[i], mdone[i]);
        end
      end
    end
    vecs++;
    if (tq.size() != 0 || done0 !== 8'd40 || spur != 0) begin
      fails++;
      $display("FAIL rnd_final got left=%0d done=%0d stray_mm=%0d want 0 40 0", tq.size(), done0, spur);
    end
  endtask

  initial begin
    @(negedge clk);
    test_reset();
    test_sequence();
    test_mismatch();
    test_back_to_back();
    test_saturate();
    test_reinit();
    test_midreset();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vecs, fails);
    $finish;
  end
endmodule
